// File: rtl/q_learn_pkg.sv
// ============================================================================
// Module      : q_learn_pkg
// Description : Shared Q-learning constants, widths and FSM state encoding.
// Revision    : 1.0
// ============================================================================
`default_nettype none

package q_learn_pkg;
    localparam int          N_STATES  = 37;
    localparam int          N_ACTIONS = 4;
    localparam int          Q_W       = 32;
    localparam int          STATE_W   = 6;
    localparam int          ACTION_W  = 3;
    localparam logic [15:0] LFSR_SEED = 16'hACE1;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_FETCH = 2'd1,
        S_LAST  = 2'd2,
        S_DONE  = 2'd3
    } as_state_e;
endpackage

`default_nettype wire

// File: rtl/action_select_if.sv
// ============================================================================
// Module      : action_select_if
// Description : Lookup request, Q-table read port and result bundle.
// Revision    : 1.0
// ============================================================================
`default_nettype none

interface action_select_if;
    import q_learn_pkg::*;

    logic                start;
    logic [STATE_W-1:0]  maze_state;
    logic [STATE_W-1:0]  q_rd_state;
    logic [ACTION_W-1:0] q_rd_action;
    logic [Q_W-1:0]      q_rd_data;
    logic                busy;
    logic                done;
    logic [Q_W-1:0]      max_Q;
    logic [ACTION_W-1:0] best_action;
    logic [ACTION_W-1:0] action;
    logic                explore;
    logic                err;

    modport master (
        output start, maze_state, q_rd_data,
        input  q_rd_state, q_rd_action, busy, done, max_Q, best_action, action, explore, err
    );

    modport slave (
        input  start, maze_state, q_rd_data,
        output q_rd_state, q_rd_action, busy, done, max_Q, best_action, action, explore, err
    );
endinterface

`default_nettype wire

// File: rtl/action_select_lfsr16.sv
// ============================================================================
// Module      : lfsr16
// Description : Free-running 16-bit Fibonacci LFSR, x^16+x^14+x^13+x^11+1.
// Revision    : 1.0
// ============================================================================
`default_nettype none

module lfsr16 #(
    parameter logic [15:0] SEED = 16'hACE1
) (
    input  wire logic       clk,
    input  wire logic       rst,
    output logic      [9:0] next_lo_o
);
    logic [15:0] lfsr_q;
    logic [15:0] lfsr_d;

    assign lfsr_d = {lfsr_q[0] ^ lfsr_q[2] ^ lfsr_q[3] ^ lfsr_q[5], lfsr_q[15:1]};

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            lfsr_q <= SEED;
        end else begin
            lfsr_q <= lfsr_d;
        end
    end

    // Expose the value the register will hold next cycle.
    assign next_lo_o = lfsr_d[9:0];
endmodule

`default_nettype wire

// File: rtl/action_select.sv
// ============================================================================
// Module      : action_select
// Description : Argmax over one Q-table row with optional epsilon-greedy
//               exploration (enabled by ACTION_SELECT_EXPLORE_EN).
// Revision    : 1.0
// ============================================================================
`default_nettype none

module action_select
    import q_learn_pkg::*;
#(
    parameter int         N_STATES  = q_learn_pkg::N_STATES,
    parameter int         N_ACTIONS = q_learn_pkg::N_ACTIONS,
    parameter logic [7:0] EPS       = 8'd26
) (
    input  wire logic      clk,
    input  wire logic      rst,
    action_select_if.slave bus
);
    as_state_e             state_q, state_d;
    logic [STATE_W-1:0]    lat_state_q, lat_state_d;
    logic [ACTION_W-1:0]   cnt_q, cnt_d;
    logic                  rd_vld_q;
    logic [ACTION_W-1:0]   rd_idx_q;
    logic signed [Q_W-1:0] run_max_q;
    logic [ACTION_W-1:0]   run_best_q;
    logic signed [Q_W-1:0] max_q;
    logic [ACTION_W-1:0]   best_q;
    logic [ACTION_W-1:0]   action_q;
    logic                  explore_q;
    logic                  err_q;
    logic                  load_res;
    logic                  load_err;
    logic                  w_take;
    logic signed [Q_W-1:0] w_max;
    logic [ACTION_W-1:0]   w_best;
    logic [9:0]            w_rnd;
    logic                  w_explore;

`ifdef ACTION_SELECT_EXPLORE_EN
    localparam bit EXPLORE_EN = 1'b1;

    lfsr16 #(
        .SEED      (LFSR_SEED)
    ) u_lfsr (
        .clk       (clk),
        .rst       (rst),
        .next_lo_o (w_rnd)
    );
`else
    localparam bit EXPLORE_EN = 1'b0;

    assign w_rnd = '0;
`endif

    assign w_explore = EXPLORE_EN && (w_rnd[7:0] < EPS);

    // Action 0 always seeds the maximum; strict > keeps the lowest index on ties.
    assign w_take = rd_vld_q && ((rd_idx_q == '0) || ($signed(bus.q_rd_data) > run_max_q));
    assign w_max  = w_take ? $signed(bus.q_rd_data) : run_max_q;
    assign w_best = w_take ? rd_idx_q : run_best_q;

    always_comb begin
        state_d     = state_q;
        lat_state_d = lat_state_q;
        cnt_d       = cnt_q;
        load_res    = 1'b0;
        load_err    = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (bus.start) begin
                    lat_state_d = bus.maze_state;
                    cnt_d       = '0;
                    if (int'(bus.maze_state) >= N_STATES) begin
                        state_d  = S_DONE;
                        load_err = 1'b1;
                    end else begin
                        state_d = S_FETCH;
                    end
                end
            end
            S_FETCH: begin
                cnt_d = cnt_q + 1'b1;
                if (cnt_q == ACTION_W'(N_ACTIONS - 1)) begin
                    state_d = S_LAST;
                end
            end
            S_LAST: begin
                state_d  = S_DONE;
                load_res = 1'b1;
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= S_IDLE;
            lat_state_q <= '0;
            cnt_q       <= '0;
            rd_vld_q    <= 1'b0;
            rd_idx_q    <= '0;
            run_max_q   <= '0;
            run_best_q  <= '0;
            max_q       <= '0;
            best_q      <= '0;
            action_q    <= '0;
            explore_q   <= 1'b0;
            err_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            lat_state_q <= lat_state_d;
            cnt_q       <= cnt_d;
            rd_vld_q    <= (state_q == S_FETCH);
            rd_idx_q    <= cnt_q;
            run_max_q   <= w_max;
            run_best_q  <= w_best;
            if (load_res) begin
                max_q     <= w_max;
                best_q    <= w_best;
                explore_q <= w_explore;
                action_q  <= w_explore ? {1'b0, w_rnd[9:8]} : w_best;
                err_q     <= 1'b0;
            end else if (load_err) begin
                max_q     <= '0;
                best_q    <= '0;
                explore_q <= 1'b0;
                action_q  <= '0;
                err_q     <= 1'b1;
            end
        end
    end

    assign bus.busy        = (state_q != S_IDLE);
    assign bus.done        = (state_q == S_DONE);
    assign bus.q_rd_state  = (state_q == S_FETCH) ? lat_state_q : '0;
    assign bus.q_rd_action = (state_q == S_FETCH) ? cnt_q : '0;
    assign bus.max_Q       = max_q;
    assign bus.best_action = best_q;
    assign bus.action      = action_q;
    assign bus.explore     = explore_q;
    assign bus.err         = err_q;
endmodule

`default_nettype wire
